caxi4interconnect_mstr_axi4_id_remap: RTL and testbench
=======================================================

// Module: caxi4interconnect_mstr_axi4_id_remap
// PURPOSE
// Master-side AXI4 ID compressor. Sits between a master port and the crossbar.
// Maps wide master IDs (MID_WIDTH) onto a small pool of internal tags (TAG_WIDTH)
// on the address channel, and restores the original ID on the response channel.
// One instance serves AR/R; a second serves AW/B, with int_masterLAST tied to 1.
// PARAMETERS
// MID_WIDTH  8  master ID width, 1-8
// TAG_WIDTH  2  internal tag width; the pool holds 2**TAG_WIDTH tags
// CNT_WIDTH  4  outstanding counter width per tag; max per tag = 2**CNT_WIDTH-1
// PORTS
// ACLK              in   1          clock, rising edge
// ARESETN           in   1          asynchronous active-low reset
// MASTER_AID        in   MID_WIDTH  master address ID
// MASTER_AVALID     in   1          master address valid
// MASTER_AREADY     out  1          address ready to master
// int_masterAID     out  TAG_WIDTH  remapped tag to crossbar
// int_masterAVALID  out  1          address valid to crossbar
// int_masterAREADY  in   1          crossbar address ready
// int_masterID      in   TAG_WIDTH  response tag from crossbar
// int_masterVALID   in   1          response valid from crossbar
// int_masterLAST    in   1          last response beat (tie 1 for B)
// int_masterREADY   out  1          response ready to crossbar
// MASTER_ID         out  MID_WIDTH  restored master ID
// MASTER_VALID      out  1          response valid to master
// MASTER_READY      in   1          master response ready
// remapIdle         out  1          1 when no tag is ACTIVE
// remapErr          out  1          sticky: response received on a FREE tag
// BEHAVIOUR
// - State per tag t: valid[t] (FREE=0 / ACTIVE=1), id[t] (MID_WIDTH), cnt[t] (CNT_WIDTH).
// - Reset (async, ARESETN=0): valid=0, cnt=0, id=0, remapErr=0. remapIdle=1.
//   All other outputs are combinational and follow the inputs below.
// - Reset asserted mid-operation drops the table; later responses raise remapErr.
// - Address path is combinational, zero added latency. All lookups use registered state.
//   hit   = some t with valid[t] & id[t]==MASTER_AID. IDs are unique, so at most one hit.
//   alloc = hit ? hit tag : lowest-index t with valid[t]==0.
//   ok    = hit ? (cnt[hit] != max) : (a FREE tag exists).
//   int_masterAID=alloc; int_masterAVALID=MASTER_AVALID&ok; MASTER_AREADY=int_masterAREADY&ok.
// - Accept (MASTER_AVALID&MASTER_AREADY):
//   miss: valid[alloc]=1, id[alloc]=MASTER_AID, cnt[alloc]=1.
//   hit:  cnt[alloc]+=1.
//   Using the same tag for the same ID preserves AXI same-ID ordering.
// - Response path is combinational pass-through:
//   MASTER_VALID=int_masterVALID; int_masterREADY=MASTER_READY.
//   MASTER_ID = valid[int_masterID] ? id[int_masterID] : 0.
// - Retire (int_masterVALID&MASTER_READY&int_masterLAST) on tag r:
//   ACTIVE tag: cnt[r]-=1; at 0, valid[r]=0 and the tag returns to FREE.
//   FREE tag: remapErr=1, state unchanged.
//   Non-LAST beats do not change any state.
// - Accept and retire in the same cycle on the same tag: net cnt unchanged, tag stays ACTIVE.
//   This holds even when cnt was 1.
// - A tag retired in cycle N is first allocatable to a new ID in cycle N+1.
// - Saturation: cnt never exceeds max and never underflows.
// - Pool full (no FREE tag and no hit): address stalls. Tags already hit still accept.
// - remapIdle = ~|valid (registered state).
// TESTING
// 1 AID=0x5A accept -> int_masterAID=0, cnt0=1. Then tag0 LAST beat -> MASTER_ID=0x5A, remapIdle=1.
// 2 AID 0x11,0x11,0x22 -> tags 0,0,1; cnt0=2. Non-LAST beat on tag0 -> cnt0 stays 2.
// 3 IDs 1,2,3,4 outstanding, then ID 5 -> MASTER_AREADY=0. Retire tag2 -> next cycle ID 5 gets tag 2.
// 4 15 accepts of ID 0x33 -> 16th stalls. One retire -> stall lifts next cycle.
// 5 cnt0=1 (ID 0x7), LAST retire tag0 and accept ID 0x7 in same cycle -> tag0 ACTIVE, cnt0=1.
// 6 Response on FREE tag3 -> MASTER_ID=0, remapErr=1 and stays 1 until ARESETN low.

Source files
------------

// File: rtl/caxi4interconnect_mstr_axi4_id_remap.sv
`default_nettype none
// ============================================================================
// Module   : caxi4interconnect_mstr_axi4_id_remap
// Purpose  : Master-side AXI4 ID compressor. Maps wide master IDs onto a small
//            pool of internal tags on the address channel and restores the
//            original ID on the response channel.
// Revision : 1.0 - initial release
// ============================================================================
module caxi4interconnect_mstr_axi4_id_remap #(
  parameter int MID_WIDTH = 8,
  parameter int TAG_WIDTH = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  // master address channel
  input  logic [MID_WIDTH-1:0] MASTER_AID,
  input  logic                 MASTER_AVALID,
  output logic                 MASTER_AREADY,
  // crossbar address channel
  output logic [TAG_WIDTH-1:0] int_masterAID,
  output logic                 int_masterAVALID,
  input  logic                 int_masterAREADY,
  // crossbar response channel
  input  logic [TAG_WIDTH-1:0] int_masterID,
  input  logic                 int_masterVALID,
  input  logic                 int_masterLAST,
  output logic                 int_masterREADY,
  // master response channel
  output logic [MID_WIDTH-1:0] MASTER_ID,
  output logic                 MASTER_VALID,
  input  logic                 MASTER_READY,
  // status
  output logic                 remapIdle,
  output logic                 remapErr
);

  localparam int                   NUM_TAGS = 1 << TAG_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Tag table: ACTIVE flag, owning master ID and outstanding count per tag
  logic [NUM_TAGS-1:0]  valid_q;
  logic [MID_WIDTH-1:0] id_q  [NUM_TAGS];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_TAGS];
  logic                 err_q;

  logic                 hit;
  logic [TAG_WIDTH-1:0] hit_tag;
  logic                 free_avail;
  logic [TAG_WIDTH-1:0] free_tag;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 addr_ok;
  logic                 accept;
  logic                 retire;
  logic                 rsp_active;
  logic [NUM_TAGS-1:0]  acc_sel;
  logic [NUM_TAGS-1:0]  ret_sel;

  // Look up the incoming ID and the lowest FREE tag; descending scan so the
  // lowest index is the last one written.
  always_comb begin
    hit        = 1'b0;
    hit_tag    = '0;
    free_avail = 1'b0;
    free_tag   = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!valid_q[t]) begin
        free_avail = 1'b1;
        free_tag   = TAG_WIDTH'(t);
      end
      if (valid_q[t] && (id_q[t] == MASTER_AID)) begin
        hit     = 1'b1;
        hit_tag = TAG_WIDTH'(t);
      end
    end
  end

  // Same ID reuses its tag (keeps AXI same-ID ordering); a new ID takes a FREE
  // tag. A hit tag stalls only at its counter ceiling.
  assign alloc_tag        = hit ? hit_tag : free_tag;
  assign addr_ok          = hit ? (cnt_q[hit_tag] != CNT_MAX) : free_avail;
  assign int_masterAID    = alloc_tag;
  assign int_masterAVALID = MASTER_AVALID & addr_ok;
  assign MASTER_AREADY    = int_masterAREADY & addr_ok;
  assign accept           = MASTER_AVALID & MASTER_AREADY;

  // Response path is a pure pass-through; only the ID is translated back.
  assign MASTER_VALID     = int_masterVALID;
  assign int_masterREADY  = MASTER_READY;
  assign rsp_active       = valid_q[int_masterID];
  assign MASTER_ID        = rsp_active ? id_q[int_masterID] : '0;
  assign retire           = int_masterVALID & MASTER_READY & int_masterLAST;

  assign remapIdle        = ~|valid_q;
  assign remapErr         = err_q;

  // Decode per-tag accept and retire strobes (retire only counts on ACTIVE tags)
  always_comb begin
    acc_sel = '0;
    ret_sel = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      acc_sel[t] = accept && (alloc_tag == TAG_WIDTH'(t));
      ret_sel[t] = retire && rsp_active && (int_masterID == TAG_WIDTH'(t));
    end
  end

  // Tag table update. Accept and retire on the same tag cancel out, so a tag
  // with one outstanding transaction stays ACTIVE when both happen together.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      valid_q <= '0;
      for (int t = 0; t < NUM_TAGS; t++) begin
        id_q[t]  <= '0;
        cnt_q[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (acc_sel[t] && !ret_sel[t]) begin
          if (!hit) begin
            valid_q[t] <= 1'b1;
            id_q[t]    <= MASTER_AID;
            cnt_q[t]   <= CNT_ONE;
          end else begin
            cnt_q[t]   <= cnt_q[t] + CNT_ONE;
          end
        end else if (ret_sel[t] && !acc_sel[t]) begin
          cnt_q[t] <= cnt_q[t] - CNT_ONE;
          if (cnt_q[t] == CNT_ONE) begin
            valid_q[t] <= 1'b0;
          end
        end
      end
    end
  end

  // Sticky error: a LAST response arrived on a tag that is not ACTIVE
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_q <= 1'b0;
    end else if (retire && !rsp_active) begin
      err_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_caxi4interconnect_mstr_axi4_id_remap.sv
`default_nettype none
// ============================================================================
// Module   : tb_caxi4interconnect_mstr_axi4_id_remap
// Purpose  : Self-checking bench: vector table, directed multi-cycle
//            sequences and randomized traffic against a tag-pool model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_caxi4interconnect_mstr_axi4_id_remap;

  logic       ACLK;
  logic       ARESETN;
  logic [7:0] MASTER_AID;
  logic       MASTER_AVALID;
  logic       MASTER_AREADY;
  logic [1:0] int_masterAID;
  logic       int_masterAVALID;
  logic       int_masterAREADY;
  logic [1:0] int_masterID;
  logic       int_masterVALID;
  logic       int_masterLAST;
  logic       int_masterREADY;
  logic [7:0] MASTER_ID;
  logic       MASTER_VALID;
  logic       MASTER_READY;
  logic       remapIdle;
  logic       remapErr;

  int checks = 0;
  int errors = 0;

  caxi4interconnect_mstr_axi4_id_remap #(
    .MID_WIDTH(8), .TAG_WIDTH(2), .CNT_WIDTH(4)
  ) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .MASTER_AID      (MASTER_AID),
    .MASTER_AVALID   (MASTER_AVALID),
    .MASTER_AREADY   (MASTER_AREADY),
    .int_masterAID   (int_masterAID),
    .int_masterAVALID(int_masterAVALID),
    .int_masterAREADY(int_masterAREADY),
    .int_masterID    (int_masterID),
    .int_masterVALID (int_masterVALID),
    .int_masterLAST  (int_masterLAST),
    .int_masterREADY (int_masterREADY),
    .MASTER_ID       (MASTER_ID),
    .MASTER_VALID    (MASTER_VALID),
    .MASTER_READY    (MASTER_READY),
    .remapIdle       (remapIdle),
    .remapErr        (remapErr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- reference model: who owns each tag, how many in flight
  int owner [4];   // -1 = FREE, else owning master ID
  int outst [4];
  bit merr;

  function automatic void model_reset();
    for (int t = 0; t < 4; t++) begin
      owner[t] = -1;
      outst[t] = 0;
    end
    merr = 1'b0;
  endfunction

  function automatic int find_hit(int aid);
    for (int t = 0; t < 4; t++) if (owner[t] == aid) return t;
    return -1;
  endfunction

  function automatic int find_free();
    for (int t = 0; t < 4; t++) if (owner[t] < 0) return t;
    return -1;
  endfunction

  function automatic bit model_ok(int aid);
    int h;
    h = find_hit(aid);
    if (h >= 0) return outst[h] < 15;
    return find_free() >= 0;
  endfunction

  // Apply one clock edge worth of traffic to the model
  function automatic void model_step();
    int  h, f, r;
    bit  acc, ret, ract;
    h    = find_hit(int'(MASTER_AID));
    f    = find_free();
    r    = int'(int_masterID);
    acc  = MASTER_AVALID && int_masterAREADY && model_ok(int'(MASTER_AID));
    ret  = int_masterVALID && MASTER_READY && int_masterLAST;
    ract = owner[r] >= 0;
    if (ret && !ract) merr = 1'b1;
    if (acc) begin
      if (h >= 0) outst[h]++;
      else begin
        owner[f] = int'(MASTER_AID);
        outst[f] = 1;
      end
    end
    if (ret && ract) begin
      outst[r]--;
      if (outst[r] == 0) owner[r] = -1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    bit ok;
    int h, f, exp_tag, exp_mid;
    bit idle;
    ok      = model_ok(int'(MASTER_AID));
    h       = find_hit(int'(MASTER_AID));
    f       = find_free();
    exp_tag = (h >= 0) ? h : f;
    exp_mid = (owner[int_masterID] >= 0) ? owner[int_masterID] : 0;
    idle    = find_free() >= 0 && owner[0] < 0 && owner[1] < 0 && owner[2] < 0 && owner[3] < 0;
    check({tag, " aready"}, 32'(MASTER_AREADY), 32'(int_masterAREADY && ok));
    check({tag, " avalid"}, 32'(int_masterAVALID), 32'(MASTER_AVALID && ok));
    if (ok) check({tag, " tag"}, 32'(int_masterAID), 32'(exp_tag));
    check({tag, " mid"}, 32'(MASTER_ID), 32'(exp_mid));
    check({tag, " mvalid"}, 32'(MASTER_VALID), 32'(int_masterVALID));
    check({tag, " iready"}, 32'(int_masterREADY), 32'(MASTER_READY));
    check({tag, " idle"}, 32'(remapIdle), 32'(idle));
    check({tag, " err"}, 32'(remapErr), 32'(merr));
  endtask

  task automatic drive(input logic [7:0] aid, input logic av, input logic iar,
                       input logic [1:0] rid, input logic rv, input logic rl, input logic mr);
    MASTER_AID       = aid;
    MASTER_AVALID    = av;
    int_masterAREADY = iar;
    int_masterID     = rid;
    int_masterVALID  = rv;
    int_masterLAST   = rl;
    MASTER_READY     = mr;
  endtask

  // Inputs are driven 1 after the edge; outputs are sampled at the falling edge
  task automatic settle();
    #4;
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    ARESETN = 1'b0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #4;
    check("reset idle", 32'(remapIdle), 32'd1);
    check("reset err", 32'(remapErr), 32'd0);
    check("reset mid", 32'(MASTER_ID), 32'd0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
  endtask

  // ---------------- vector table
  typedef struct {
    logic [7:0] aid;
    logic       av, iar;
    logic [1:0] rid;
    logic       rv, rl, mr;
    logic [1:0] e_tag;
    logic       e_aready, e_avalid;
    logic [7:0] e_mid;
    logic       e_idle, e_err;
  } vec_t;

  function automatic vec_t mk(logic [7:0] aid, logic av, logic iar, logic [1:0] rid,
                              logic rv, logic rl, logic mr, logic [1:0] et, logic ea,
                              logic eav, logic [7:0] em, logic ei, logic ee);
    vec_t v;
    v.aid = aid; v.av = av; v.iar = iar; v.rid = rid; v.rv = rv; v.rl = rl; v.mr = mr;
    v.e_tag = et; v.e_aready = ea; v.e_avalid = eav; v.e_mid = em; v.e_idle = ei; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    //               aid   av iar rid rv rl mr  tag ard avo mid  idle err
    tbl[0]  = mk(8'h5A, 1, 1, 0, 0, 0, 1,  0, 1, 1, 8'h00, 1, 0);
    tbl[1]  = mk(8'h00, 0, 1, 0, 1, 1, 1,  1, 1, 0, 8'h5A, 0, 0);
    tbl[2]  = mk(8'h00, 0, 1, 0, 0, 0, 1,  0, 1, 0, 8'h00, 1, 0);
    tbl[3]  = mk(8'h11, 1, 1, 0, 0, 0, 1,  0, 1, 1, 8'h00, 1, 0);
    tbl[4]  = mk(8'h11, 1, 1, 0, 0, 0, 1,  0, 1, 1, 8'h11, 0, 0);
    tbl[5]  = mk(8'h22, 1, 1, 0, 0, 0, 1,  1, 1, 1, 8'h11, 0, 0);
    tbl[6]  = mk(8'h11, 0, 1, 0, 1, 0, 1,  0, 1, 0, 8'h11, 0, 0);
    tbl[7]  = mk(8'h00, 0, 1, 0, 1, 1, 1,  2, 1, 0, 8'h11, 0, 0);
    tbl[8]  = mk(8'h00, 0, 1, 0, 1, 1, 1,  2, 1, 0, 8'h11, 0, 0);
    tbl[9]  = mk(8'h00, 0, 1, 1, 1, 1, 1,  0, 1, 0, 8'h22, 0, 0);
    tbl[10] = mk(8'h00, 0, 1, 0, 0, 0, 1,  0, 1, 0, 8'h00, 1, 0);
    tbl[11] = mk(8'h07, 1, 1, 0, 0, 0, 1,  0, 1, 1, 8'h00, 1, 0);
    tbl[12] = mk(8'h07, 1, 1, 0, 1, 1, 1,  0, 1, 1, 8'h07, 0, 0);
    tbl[13] = mk(8'h07, 0, 1, 0, 0, 0, 1,  0, 1, 0, 8'h07, 0, 0);
    tbl[14] = mk(8'h00, 0, 1, 0, 1, 1, 1,  1, 1, 0, 8'h07, 0, 0);
    tbl[15] = mk(8'h00, 0, 1, 3, 1, 1, 1,  0, 1, 0, 8'h00, 1, 0);
    tbl[16] = mk(8'h00, 0, 1, 3, 0, 0, 1,  0, 1, 0, 8'h00, 1, 1);
    tbl[17] = mk(8'h44, 1, 0, 3, 0, 0, 1,  0, 0, 1, 8'h00, 1, 1);

    ARESETN = 1'b0;
    model_reset();
    do_reset();

    // ---- table-driven vectors (one row per clock)
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].aid, tbl[i].av, tbl[i].iar, tbl[i].rid, tbl[i].rv, tbl[i].rl, tbl[i].mr);
      settle();
      check($sformatf("vec%0d tag", i), 32'(int_masterAID), 32'(tbl[i].e_tag));
      check($sformatf("vec%0d aready", i), 32'(MASTER_AREADY), 32'(tbl[i].e_aready));
      check($sformatf("vec%0d avalid", i), 32'(int_masterAVALID), 32'(tbl[i].e_avalid));
      check($sformatf("vec%0d mid", i), 32'(MASTER_ID), 32'(tbl[i].e_mid));
      check($sformatf("vec%0d mvalid", i), 32'(MASTER_VALID), 32'(tbl[i].rv));
      check($sformatf("vec%0d iready", i), 32'(int_masterREADY), 32'(tbl[i].mr));
      check($sformatf("vec%0d idle", i), 32'(remapIdle), 32'(tbl[i].e_idle));
      check($sformatf("vec%0d err", i), 32'(remapErr), 32'(tbl[i].e_err));
      tick();
    end
    do_reset();   // also shows the sticky error clears only on reset

    // ---- pool full: IDs 1..4 occupy tags 0..3, ID 5 stalls until a retire
    for (int i = 0; i < 4; i++) begin
      drive(8'(i + 1), 1, 1, 0, 0, 0, 1);
      settle();
      check("full fill tag", 32'(int_masterAID), 32'(i));
      check("full fill aready", 32'(MASTER_AREADY), 32'd1);
      tick();
    end
    drive(8'h05, 1, 1, 0, 0, 0, 1);
    settle();
    check("full stall aready", 32'(MASTER_AREADY), 32'd0);
    check("full stall avalid", 32'(int_masterAVALID), 32'd0);
    tick();
    drive(8'h05, 1, 1, 2, 1, 1, 1);
    settle();
    check("full retire-cycle aready", 32'(MASTER_AREADY), 32'd0);
    check("full retire mid", 32'(MASTER_ID), 32'h03);
    tick();
    drive(8'h05, 1, 1, 2, 0, 0, 1);
    settle();
    check("full reuse aready", 32'(MASTER_AREADY), 32'd1);
    check("full reuse tag", 32'(int_masterAID), 32'd2);
    tick();
    drive(8'h00, 0, 1, 2, 0, 0, 1);
    settle();
    check("full reuse mid", 32'(MASTER_ID), 32'h05);
    tick();
    do_reset();

    // ---- counter saturation on one ID
    for (int i = 0; i < 15; i++) begin
      drive(8'h33, 1, 1, 0, 0, 0, 1);
      settle();
      check("sat fill aready", 32'(MASTER_AREADY), 32'd1);
      check("sat fill tag", 32'(int_masterAID), 32'd0);
      tick();
    end
    drive(8'h33, 1, 1, 0, 1, 1, 1);
    settle();
    check("sat stall aready", 32'(MASTER_AREADY), 32'd0);
    check("sat stall avalid", 32'(int_masterAVALID), 32'd0);
    tick();
    drive(8'h33, 1, 1, 0, 0, 0, 1);
    settle();
    check("sat lift aready", 32'(MASTER_AREADY), 32'd1);
    tick();

    // ---- asynchronous reset mid-operation, then a stale response
    drive(8'h00, 0, 1, 0, 0, 0, 1);
    #1;
    ARESETN = 1'b0;
    model_reset();
    #1;
    check("async idle", 32'(remapIdle), 32'd1);
    check("async mid", 32'(MASTER_ID), 32'd0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    drive(8'h00, 0, 1, 0, 1, 1, 1);
    settle();
    check("stale err before", 32'(remapErr), 32'd0);
    tick();
    drive(8'h00, 0, 1, 0, 0, 0, 1);
    settle();
    check("stale err after", 32'(remapErr), 32'd1);
    tick();
    do_reset();

    // ---- randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive(8'($urandom_range(0, 5)), 1'($urandom % 2), 1'(($urandom % 4) != 0),
            2'($urandom % 4), 1'($urandom % 2), 1'(($urandom % 3) != 0),
            1'(($urandom % 4) != 0));
      settle();
      compare_model("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
